// File: rtl/mem_bus_router.sv
// Address-window router between the picorv32 native memory port and N slaves.
// Unmapped or unanswered accesses complete with ERR_RDATA and raise a sticky error.

module mem_bus_router_match #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] i_addr,
  output logic        o_hit
);
  assign o_hit = ((i_addr & MASK) == BASE);
endmodule

module mem_bus_router #(
  parameter int              N         = 3,
  parameter logic [N*32-1:0] BASE      = {N{32'h0}},
  parameter logic [N*32-1:0] MASK      = {N{32'h0}},
  parameter int              TIMEOUT   = 1024,
  parameter logic [31:0]     ERR_RDATA = 32'hDEADBEEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            cpu_mem_valid,
  input  logic [31:0]     cpu_mem_addr,
  input  logic [3:0]      cpu_mem_wstrb,
  output logic            cpu_mem_ready,
  output logic [31:0]     cpu_mem_rdata,
  output logic [N-1:0]    dev_mem_valid,
  input  logic [N-1:0]    dev_mem_ready,
  input  logic [32*N-1:0] dev_mem_rdata,
  input  logic            err_clear,
  output logic            bus_err,
  output logic [31:0]     bus_err_addr,
  output logic            bus_err_timeout
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR, S_RESP} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_dev_vld;
  logic            r_ready;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_err_addr;
  logic            r_err_to;
  logic            r_cause_to;

  logic [N-1:0]        w_hit;
  logic [N-1:0]        w_first;
  logic [SW-1:0]       w_idx;
  logic                w_any;
  logic                w_dev_rdy;
  logic [N-1:0][31:0]  w_rdata;
  logic                w_unused;

  // Write data and strobes travel to the slaves outside this block.
  assign w_unused = ^cpu_mem_wstrb;
  assign w_rdata  = dev_mem_rdata;

  for (genvar g = 0; g < N; g++) begin : g_match
    mem_bus_router_match #(
      .BASE(BASE[g*32 +: 32]),
      .MASK(MASK[g*32 +: 32])
    ) u_match (
      .i_addr(cpu_mem_addr),
      .o_hit (w_hit[g])
    );
  end

  // Lowest matching index wins; w_first isolates that bit.
  assign w_first = w_hit & (~w_hit + N'(1));
  assign w_any   = |w_hit;

  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (w_hit[i]) w_idx = SW'(i);
  end

  assign w_dev_rdy = |(dev_mem_ready & r_dev_vld);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_dev_vld  <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_err_to   <= 1'b0;
      r_cause_to <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      // A new error in the ERR branch below overrides this clear.
      if (err_clear) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_mem_valid) begin
            if (w_any) begin
              r_sel     <= w_idx;
              r_cnt     <= '0;
              r_dev_vld <= w_first;
              r_state   <= S_WAIT;
            end else begin
              r_cause_to <= 1'b0;
              r_state    <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_dev_rdy) begin
            r_rdata   <= w_rdata[r_sel];
            r_dev_vld <= '0;
            r_ready   <= 1'b1;
            r_state   <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_dev_vld  <= '0;
            r_cause_to <= 1'b1;
            r_state    <= S_ERR;
          end
        end
        S_ERR: begin
          r_rdata    <= ERR_RDATA;
          r_err      <= 1'b1;
          r_err_addr <= cpu_mem_addr;
          r_err_to   <= r_cause_to;
          r_ready    <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_mem_ready   = r_ready;
  assign cpu_mem_rdata   = r_rdata;
  assign dev_mem_valid   = r_dev_vld;
  assign bus_err         = r_err;
  assign bus_err_addr    = r_err_addr;
  assign bus_err_timeout = r_err_to;

endmodule

// File: tb/tb_mem_bus_router.sv
// Randomised bench for mem_bus_router against a transaction-level reference model.
module tb_mem_bus_router;
  localparam int N = 3;
  localparam int TMO = 8;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;
  localparam logic [N*32-1:0] P_BASE = {32'h2000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] P_MASK = {32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_0000};

  logic            clk = 1'b0;
  logic            nrst = 1'b1;
  logic            cpu_mem_valid = 1'b0;
  logic [31:0]     cpu_mem_addr = '0;
  logic [3:0]      cpu_mem_wstrb = '0;
  logic            cpu_mem_ready;
  logic [31:0]     cpu_mem_rdata;
  logic [N-1:0]    dev_mem_valid;
  logic [N-1:0]    dev_mem_ready = '0;
  logic [N*32-1:0] dev_mem_rdata = '0;
  logic            err_clear = 1'b0;
  logic            bus_err;
  logic [31:0]     bus_err_addr;
  logic            bus_err_timeout;

  // Second instance with overlapping windows: slave1 matches every address.
  logic        b_valid = 1'b0;
  logic [31:0] b_addr = '0;
  logic        b_ready;
  logic [31:0] b_rdata;
  logic [1:0]  b_dvld;
  logic [1:0]  b_drdy = '0;
  logic [63:0] b_drdata = '0;
  logic        b_err;
  logic [31:0] b_err_addr;
  logic        b_err_to;

  mem_bus_router #(.N(N), .BASE(P_BASE), .MASK(P_MASK), .TIMEOUT(TMO), .ERR_RDATA(ERRW)) u_dut (
    .clk(clk), .nrst(nrst), .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .dev_mem_valid(dev_mem_valid), .dev_mem_ready(dev_mem_ready), .dev_mem_rdata(dev_mem_rdata),
    .err_clear(err_clear), .bus_err(bus_err), .bus_err_addr(bus_err_addr),
    .bus_err_timeout(bus_err_timeout));

  mem_bus_router #(.N(2), .BASE({32'h0, 32'h0}), .MASK({32'h0, 32'hFFFF_0000}), .TIMEOUT(16)) u_ovl (
    .clk(clk), .nrst(nrst), .cpu_mem_valid(b_valid), .cpu_mem_addr(b_addr),
    .cpu_mem_wstrb(4'h0), .cpu_mem_ready(b_ready), .cpu_mem_rdata(b_rdata),
    .dev_mem_valid(b_dvld), .dev_mem_ready(b_drdy), .dev_mem_rdata(b_drdata),
    .err_clear(1'b0), .bus_err(b_err), .bus_err_addr(b_err_addr), .bus_err_timeout(b_err_to));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_base [N] = '{32'h0000_0000, 32'h4000_0000, 32'h2000_0000};
  logic [31:0] ref_mask [N] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hF000_0000};

  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  logic        m_err_to = 1'b0;
  logic [31:0] m_rdata = '0;
  int          e_lat, e_vcyc;

  int          o_lat, o_vcyc;
  bit          o_seen, o_other, o_after;
  logic [31:0] o_rdata;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & ref_mask[i]) == ref_base[i]) return i;
    return -1;
  endfunction

  // lat = WAIT cycle on which the slave answers (0 = never).
  task automatic ref_txn(input logic [31:0] a, input int lat, input logic [31:0] d, input bit clr);
    int idx;
    idx = ref_decode(a);
    if (clr) m_err = 1'b0;
    if (idx < 0) begin
      e_lat = 2; e_vcyc = 0;
      m_rdata = ERRW; m_err = 1'b1; m_err_addr = a; m_err_to = 1'b0;
    end else if (lat >= 1 && lat <= TMO) begin
      e_lat = lat + 1; e_vcyc = lat; m_rdata = d;
    end else begin
      e_lat = TMO + 2; e_vcyc = TMO;
      m_rdata = ERRW; m_err = 1'b1; m_err_addr = a; m_err_to = 1'b1;
    end
  endtask

  // Drives one CPU access and plays the slaves; returns one cycle after the ready pulse.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] ws, input int lat,
                         input logic [31:0] d, input bit stray, input bit clr);
    int idx, vc, edges;
    logic [N-1:0] selb;
    idx = ref_decode(a);
    selb = (idx >= 0) ? N'(1 << idx) : '0;
    vc = 0; edges = 0; o_seen = 0; o_other = 0; o_lat = -1;
    cpu_mem_valid = 1'b1; cpu_mem_addr = a; cpu_mem_wstrb = ws; err_clear = clr;
    dev_mem_ready = stray ? ~selb : '0;
    while (!o_seen && edges < TMO + 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if ((dev_mem_valid & ~selb) != '0) o_other = 1;
      if ((dev_mem_valid & selb) != '0) vc++;
      if (cpu_mem_ready) begin o_seen = 1; o_lat = edges; o_rdata = cpu_mem_rdata; end
      dev_mem_ready = stray ? ~selb : '0;
      for (int i = 0; i < N; i++) dev_mem_rdata[i*32 +: 32] = $urandom;
      if ((dev_mem_valid & selb) != '0 && vc == lat) begin
        dev_mem_ready = dev_mem_ready | selb;
        dev_mem_rdata[idx*32 +: 32] = d;
      end
    end
    o_vcyc = vc;
    cpu_mem_valid = 1'b0; err_clear = 1'b0; dev_mem_ready = '0;
    @(posedge clk); @(negedge clk);
    o_after = cpu_mem_ready;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({cpu_mem_ready, cpu_mem_rdata, dev_mem_valid, bus_err, bus_err_addr, bus_err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h dvld=%b err=%b addr=%h to=%b, want all zero",
               cpu_mem_ready, cpu_mem_rdata, dev_mem_valid, bus_err, bus_err_addr, bus_err_timeout);
    end
    checks++;
    if ({b_ready, b_rdata, b_dvld, b_err} !== '0) begin
      errors++; $display("FAIL reset_ovl: got ready=%b rdata=%h dvld=%b err=%b, want zero", b_ready, b_rdata, b_dvld, b_err);
    end
    @(negedge clk); nrst = 1'b1; @(negedge clk);
  endtask

  task automatic test_zero_wait();
    ref_txn(32'h0000_0010, 1, 32'h1234_5678, 0);
    run_txn(32'h0000_0010, 4'h0, 1, 32'h1234_5678, 0, 0);
    checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL zw_latency: got %0d want %0d", o_lat, e_lat); end
    checks++; if (o_vcyc !== 1 || o_other) begin errors++; $display("FAIL zw_dev_valid: got %0d cycles other=%b want 1 cycle, other=0", o_vcyc, o_other); end
    checks++; if (o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL zw_rdata: got %h want 12345678", o_rdata); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL zw_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_wait_write();
    ref_txn(32'h4000_0004, 5, 32'h0BAD_F00D, 0);
    run_txn(32'h4000_0004, 4'hF, 5, 32'h0BAD_F00D, 0, 0);
    checks++; if (o_vcyc !== 5 || o_other) begin errors++; $display("FAIL ww_dev_valid: got %0d cycles other=%b want 5, other=0", o_vcyc, o_other); end
    checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL ww_latency: got %0d want %0d", o_lat, e_lat); end
    checks++; if (o_after !== 1'b0) begin errors++; $display("FAIL ww_single_pulse: ready still %b one cycle later, want 0", o_after); end
  endtask

  task automatic test_unmapped();
    ref_txn(32'h8000_0000, 1, 0, 0);
    run_txn(32'h8000_0000, 4'h0, 1, 0, 0, 0);
    checks++; if (o_lat !== 2 || o_other) begin errors++; $display("FAIL um_latency: got %0d other=%b want 2, no dev valid", o_lat, o_other); end
    checks++; if (o_rdata !== ERRW) begin errors++; $display("FAIL um_rdata: got %h want %h", o_rdata, ERRW); end
    checks++;
    if ({bus_err, bus_err_addr, bus_err_timeout} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      errors++; $display("FAIL um_status: got err=%b addr=%h to=%b want 1 80000000 0", bus_err, bus_err_addr, bus_err_timeout);
    end
  endtask

  task automatic test_timeout();
    ref_txn(32'h2000_0100, 0, 0, 0);
    run_txn(32'h2000_0100, 4'h0, 0, 0, 0, 0);
    checks++; if (o_vcyc !== TMO || o_lat !== TMO + 2) begin errors++; $display("FAIL to_timing: got vcyc=%0d lat=%0d want %0d %0d", o_vcyc, o_lat, TMO, TMO + 2); end
    checks++;
    if ({o_rdata, bus_err, bus_err_addr, bus_err_timeout} !== {ERRW, 1'b1, 32'h2000_0100, 1'b1}) begin
      errors++; $display("FAIL to_status: got rdata=%h err=%b addr=%h to=%b", o_rdata, bus_err, bus_err_addr, bus_err_timeout);
    end
    err_clear = 1'b1; @(negedge clk); err_clear = 1'b0; m_err = 1'b0;
    checks++;
    if ({bus_err, bus_err_addr, bus_err_timeout} !== {1'b0, 32'h2000_0100, 1'b1}) begin
      errors++; $display("FAIL err_clear_only: got err=%b addr=%h to=%b want 0 20000100 1", bus_err, bus_err_addr, bus_err_timeout);
    end
    ref_txn(32'h2000_0104, TMO, 32'hCAFE_0008, 0);
    run_txn(32'h2000_0104, 4'h0, TMO, 32'hCAFE_0008, 0, 0);
    checks++; if (o_lat !== TMO + 1 || o_rdata !== 32'hCAFE_0008) begin errors++; $display("FAIL ready_at_limit: got lat=%0d rdata=%h want %0d cafe0008", o_lat, o_rdata, TMO + 1); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ready_at_limit_err: got %b want 0", bus_err); end
  endtask

  task automatic test_overlap();
    int n;
    b_valid = 1'b1; b_addr = 32'h0000_0000;
    @(negedge clk);
    checks++; if (b_dvld !== 2'b01) begin errors++; $display("FAIL ovl_priority: got %b want 01", b_dvld); end
    b_drdy = 2'b10; b_drdata = {32'h1111_1111, 32'h2222_2222};
    repeat (2) @(negedge clk);
    checks++; if (b_ready !== 1'b0 || b_dvld !== 2'b01) begin errors++; $display("FAIL ovl_stray_ready: got ready=%b dvld=%b want 0 01", b_ready, b_dvld); end
    b_drdy = 2'b01; b_drdata = {32'h1111_1111, 32'hA5A5_0000};
    n = 0;
    while (!b_ready && n < 8) begin @(negedge clk); n++; end
    b_valid = 1'b0; b_drdy = '0;
    checks++; if (b_ready !== 1'b1 || b_rdata !== 32'hA5A5_0000 || b_err !== 1'b0) begin errors++; $display("FAIL ovl_resp: got ready=%b rdata=%h err=%b want 1 a5a50000 0", b_ready, b_rdata, b_err); end
    @(negedge clk);
    b_valid = 1'b1; b_addr = 32'h1234_0000;
    @(negedge clk);
    checks++; if (b_dvld !== 2'b10) begin errors++; $display("FAIL ovl_catch_all: got %b want 10", b_dvld); end
    b_drdy = 2'b10; b_drdata = {32'h7777_0001, 32'h0};
    n = 0;
    while (!b_ready && n < 8) begin @(negedge clk); n++; end
    b_valid = 1'b0; b_drdy = '0;
    checks++; if (b_rdata !== 32'h7777_0001) begin errors++; $display("FAIL ovl_catch_all_rdata: got %h want 77770001", b_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4] = '{32'h0000_0200, 32'h4000_0010, 32'hF000_0000, 32'h2000_0000};
    int l [4] = '{1, 3, 1, 2};
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      ref_txn(a[k], l[k], d, 0);
      run_txn(a[k], 4'h0, l[k], d, 0, 0);
      checks++;
      if (o_lat !== e_lat || o_rdata !== m_rdata) begin
        errors++; $display("FAIL b2b_%0d: got lat=%0d rdata=%h want %0d %h", k, o_lat, o_rdata, e_lat, m_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    ref_txn(32'h9000_0000, 1, 0, 0);
    run_txn(32'h9000_0000, 4'h0, 1, 0, 0, 0);
    cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h2000_0040; cpu_mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (dev_mem_valid !== 3'b100) begin errors++; $display("FAIL mid_wait_valid: got %b want 100", dev_mem_valid); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({cpu_mem_ready, cpu_mem_rdata, dev_mem_valid, bus_err, bus_err_addr, bus_err_timeout} !== '0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b rdata=%h dvld=%b err=%b addr=%h to=%b, want all zero",
               cpu_mem_ready, cpu_mem_rdata, dev_mem_valid, bus_err, bus_err_addr, bus_err_timeout);
    end
    cpu_mem_valid = 1'b0;
    m_err = 1'b0; m_err_addr = '0; m_err_to = 1'b0; m_rdata = '0;
    @(negedge clk); nrst = 1'b1; @(negedge clk);
    ref_txn(32'hC000_0000, 0, 0, 1);
    run_txn(32'hC000_0000, 4'hF, 0, 0, 0, 1);
    checks++;
    if ({o_lat, bus_err, bus_err_addr, bus_err_timeout} !== {32'(e_lat), 1'b1, 32'hC000_0000, 1'b0}) begin
      errors++; $display("FAIL clear_vs_set: got lat=%0d err=%b addr=%h to=%b want %0d 1 c0000000 0", o_lat, bus_err, bus_err_addr, bus_err_timeout, e_lat);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, d;
      int lat;
      bit st, clr;
      case ($urandom_range(0, 3))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {24'h40_0000, 8'($urandom)};
        2:       a = {4'h2, 28'($urandom)};
        default: a = {4'($urandom_range(8, 15)), 28'($urandom)};
      endcase
      lat = $urandom_range(0, TMO + 2);
      d   = $urandom;
      st  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 3) == 0);
      ref_txn(a, lat, d, clr);
      run_txn(a, 4'($urandom), lat, d, st, clr);
      checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: addr=%h lat=%0d got %0d want %0d", k, a, lat, o_lat, e_lat); end
      checks++; if (o_vcyc !== e_vcyc || o_other) begin errors++; $display("FAIL rnd%0d_dev_valid: got %0d other=%b want %0d", k, o_vcyc, o_other, e_vcyc); end
      checks++; if (o_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_pulse: ready held %b", k, o_after); end
      checks++; if (o_rdata !== m_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", k, o_rdata, m_rdata); end
      checks++;
      if ({bus_err, bus_err_addr, bus_err_timeout} !== {m_err, m_err_addr, m_err_to}) begin
        errors++; $display("FAIL rnd%0d_status: got %b %h %b want %b %h %b", k, bus_err, bus_err_addr, bus_err_timeout, m_err, m_err_addr, m_err_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_write();
    test_unmapped();
    test_timeout();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
